charge_timer_mc: RTL and testbench

- Multi-channel countdown timer for the charger: one independent charge session per output socket.
- Each channel is loaded with a charge duration in ticks, counts down on a shared 1 kHz tick enable, and can be paused, resumed, topped up by later coins, or cancelled.
- Sits between the coin/price logic, which issues commands, and the socket relay drivers and display, which consume busy/remaining/done.
- Generalises the single-channel up-counter to N channels and adds a richer mode set.

---
 rtl/charger_pkg.sv | 22 ++
 rtl/charge_timer_ch.sv | 104 ++++++++++
 rtl/charge_timer_mc.sv | 64 ++++++
 tb/tb_charge_timer_mc.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/charger_pkg.sv
// Shared types and helpers for the charger session timers.
package charger_pkg;

    localparam int unsigned CNT_W_DEF   = 14;
    localparam int unsigned MAXTIME_DEF = 10000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } timer_state_e;

    // Adds two counts with one guard bit and clamps the result to ceil.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] ceil);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, ceil}) ? ceil : s[31:0];
    endfunction

endpackage

// File: rtl/charge_timer_ch.sv
// One socket's session timer: IDLE/RUN/PAUSE FSM with a saturating countdown.
module charge_timer_ch
    import charger_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned MAXTIME = MAXTIME_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             do_start,
    input  logic             do_add,
    input  logic             do_pause,
    input  logic             do_resume,
    input  logic             do_cancel,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             paused,
    output logic             done_pulse,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAXTIME);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    timer_state_e     state;
    logic [CNT_W-1:0] topped_c;
    logic [CNT_W-1:0] clipped_c;

    always_comb begin
        topped_c  = CNT_W'(sat_add(32'(remaining), 32'(load_val), 32'(MAXTIME)));
        clipped_c = (load_val > MAX_C) ? MAX_C : load_val;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            busy       <= 1'b0;
            paused     <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (do_start && load_val != '0) begin
                        state     <= ST_RUN;
                        remaining <= clipped_c;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (do_cancel) begin
                        state     <= ST_IDLE;
                        remaining <= '0;
                        busy      <= 1'b0;
                    end else if (do_add) begin
                        // A top-up landing on the expiring tick keeps the session alive.
                        if (tick && topped_c == ONE_C) begin
                            state      <= ST_IDLE;
                            remaining  <= '0;
                            busy       <= 1'b0;
                            done_pulse <= 1'b1;
                        end else if (tick) begin
                            remaining <= topped_c - ONE_C;
                        end else begin
                            remaining <= topped_c;
                        end
                    end else if (do_pause) begin
                        state  <= ST_PAUSE;
                        paused <= 1'b1;
                    end else if (tick) begin
                        if (remaining == ONE_C) begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            done_pulse <= 1'b1;
                        end
                        remaining <= remaining - ONE_C;
                    end
                end
                ST_PAUSE: begin
                    if (do_cancel) begin
                        state     <= ST_IDLE;
                        remaining <= '0;
                        busy      <= 1'b0;
                        paused    <= 1'b0;
                    end else if (do_add) begin
                        remaining <= topped_c;
                    end else if (do_resume) begin
                        state  <= ST_RUN;
                        paused <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    remaining <= '0;
                    busy      <= 1'b0;
                    paused    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/charge_timer_mc.sv
// Multi-socket charge timer: decodes commands to one channel and flattens per-channel status.
module charge_timer_mc
    import charger_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned MAXTIME  = MAXTIME_DEF,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [CH_W-1:0]           ch_sel,
    input  logic                      cmd_start,
    input  logic                      cmd_add,
    input  logic                      cmd_pause,
    input  logic                      cmd_resume,
    input  logic                      cmd_cancel,
    input  logic [CNT_W-1:0]          load_val,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       paused,
    output logic [CHANNELS-1:0]       done_pulse,
    output logic [CHANNELS*CNT_W-1:0] remaining
);

    logic ch_valid_c;
    logic start_c, add_c, pause_c, resume_c, cancel_c;

    // Only the highest-priority strobe is forwarded: cancel > start > add > pause > resume.
    always_comb begin
        ch_valid_c = 32'(ch_sel) < CHANNELS;
        cancel_c   = ch_valid_c && cmd_cancel;
        start_c    = ch_valid_c && !cmd_cancel && cmd_start;
        add_c      = ch_valid_c && !cmd_cancel && !cmd_start && cmd_add;
        pause_c    = ch_valid_c && !cmd_cancel && !cmd_start && !cmd_add && cmd_pause;
        resume_c   = ch_valid_c && !cmd_cancel && !cmd_start && !cmd_add && !cmd_pause
                     && cmd_resume;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic hit_c;
        assign hit_c = (ch_sel == CH_W'(i));

        charge_timer_ch #(
            .CNT_W   (CNT_W),
            .MAXTIME (MAXTIME)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .do_start   (hit_c && start_c),
            .do_add     (hit_c && add_c),
            .do_pause   (hit_c && pause_c),
            .do_resume  (hit_c && resume_c),
            .do_cancel  (hit_c && cancel_c),
            .load_val   (load_val),
            .busy       (busy[i]),
            .paused     (paused[i]),
            .done_pulse (done_pulse[i]),
            .remaining  (remaining[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_charge_timer_mc.sv
// Directed-vector bench for charge_timer_mc with hand-computed expectations.
module tb_charge_timer_mc;

    localparam int unsigned CNT_W = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick;
    logic [1:0]        ch_sel;
    logic              cmd_start, cmd_add, cmd_pause, cmd_resume, cmd_cancel;
    logic [CNT_W-1:0]  load_val;

    logic [3:0]        busy, paused, done_pulse;
    logic [4*CNT_W-1:0] remaining;
    logic [2:0]        busy3, paused3, done3;
    logic [3*CNT_W-1:0] remaining3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    charge_timer_mc dut (
        .clk(clk), .reset(reset), .tick(tick), .ch_sel(ch_sel),
        .cmd_start(cmd_start), .cmd_add(cmd_add), .cmd_pause(cmd_pause),
        .cmd_resume(cmd_resume), .cmd_cancel(cmd_cancel), .load_val(load_val),
        .busy(busy), .paused(paused), .done_pulse(done_pulse), .remaining(remaining)
    );

    // Three-channel instance so that ch_sel == CHANNELS is representable.
    charge_timer_mc #(.CHANNELS(3)) dut3 (
        .clk(clk), .reset(reset), .tick(tick), .ch_sel(ch_sel),
        .cmd_start(cmd_start), .cmd_add(cmd_add), .cmd_pause(cmd_pause),
        .cmd_resume(cmd_resume), .cmd_cancel(cmd_cancel), .load_val(load_val),
        .busy(busy3), .paused(paused3), .done_pulse(done3), .remaining(remaining3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rem(input int i);
        return 32'(remaining[i*CNT_W +: CNT_W]);
    endfunction

    // One clock with the given strobes; outputs are sampled 1 ns after the edge.
    task automatic step(input logic t, input logic [1:0] sel, input logic st, input logic ad,
                        input logic pa, input logic re, input logic ca, input int lv);
        tick = t; ch_sel = sel; cmd_start = st; cmd_add = ad;
        cmd_pause = pa; cmd_resume = re; cmd_cancel = ca; load_val = CNT_W'(lv);
        @(posedge clk);
        #1;
        tick = 1'b0; cmd_start = 1'b0; cmd_add = 1'b0;
        cmd_pause = 1'b0; cmd_resume = 1'b0; cmd_cancel = 1'b0; load_val = '0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; ch_sel = '0; load_val = '0;
        cmd_start = 1'b0; cmd_add = 1'b0; cmd_pause = 1'b0; cmd_resume = 1'b0; cmd_cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_paused", 32'(paused), 0);
        chk("rst_done", 32'(done_pulse), 0);
        chk("rst_rem", 32'(|remaining), 0);

        // Basic countdown; coincident tick on start does not decrement.
        step(1, 0, 1, 0, 0, 0, 0, 5);
        chk("cd_load", rem(0), 5);
        chk("cd_busy", 32'(busy[0]), 1);
        for (int k = 4; k >= 1; k--) begin
            ticks(1);
            chk("cd_rem", rem(0), 32'(k));
            chk("cd_nodone", 32'(done_pulse[0]), 0);
        end
        ticks(1);
        chk("cd_zero", rem(0), 0);
        chk("cd_done", 32'(done_pulse[0]), 1);
        chk("cd_busy_drop", 32'(busy[0]), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("cd_done_1clk", 32'(done_pulse[0]), 0);

        // Saturation on add and on start.
        step(0, 1, 1, 0, 0, 0, 0, 9990);
        chk("sat_load", rem(1), 9990);
        step(0, 1, 0, 1, 0, 0, 0, 50);
        chk("sat_add", rem(1), 10000);
        step(0, 2, 1, 0, 0, 0, 0, 16383);
        chk("sat_start", rem(2), 10000);
        chk("sat_iso", rem(1), 10000);
        step(0, 2, 1, 0, 0, 0, 0, 3);
        chk("run_start_ign", rem(2), 10000);
        step(0, 1, 0, 0, 0, 0, 1, 0);
        step(0, 2, 0, 0, 0, 0, 1, 0);
        chk("sat_cancel", 32'(busy), 0);

        // Pause with a coincident tick, hold, resume and expire.
        step(0, 0, 1, 0, 0, 0, 0, 3);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        chk("pause_rem", rem(0), 3);
        chk("pause_flag", 32'(paused[0]), 1);
        chk("pause_busy", 32'(busy[0]), 1);
        ticks(10);
        chk("pause_hold", rem(0), 3);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        chk("resume_rem", rem(0), 3);
        chk("resume_flag", 32'(paused[0]), 0);
        ticks(2);
        chk("resume_cnt", rem(0), 1);
        ticks(1);
        chk("resume_done", 32'(done_pulse[0]), 1);

        // Expiry collides with a top-up.
        step(0, 0, 1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0, 0, 4);
        chk("coll_rem", rem(0), 4);
        chk("coll_busy", 32'(busy[0]), 1);
        chk("coll_nodone", 32'(done_pulse[0]), 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);

        // Cancel with a coincident tick, zero-length start, out-of-range select.
        step(0, 3, 1, 0, 0, 0, 0, 10);
        ticks(2);
        chk("c3_rem", rem(3), 8);
        step(1, 3, 0, 0, 0, 0, 1, 0);
        chk("c3_cancel_rem", rem(3), 0);
        chk("c3_cancel_busy", 32'(busy[3]), 0);
        chk("c3_cancel_nodone", 32'(done_pulse[3]), 0);
        step(0, 3, 1, 0, 0, 0, 0, 0);
        chk("zero_start", 32'(busy[3]), 0);
        chk("zero_nodone", 32'(done_pulse[3]), 0);
        step(0, 3, 1, 0, 0, 0, 0, 7);
        chk("oob_busy", 32'(busy3), 0);
        chk("oob_rem", 32'(|remaining3), 0);
        chk("inrange_start", rem(3), 7);

        // Asynchronous reset between clock edges with every channel running.
        step(0, 0, 1, 0, 0, 0, 0, 100);
        step(0, 1, 1, 0, 0, 0, 0, 200);
        step(0, 2, 1, 0, 0, 0, 0, 300);
        chk("all_busy", 32'(busy), 32'hF);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rem", 32'(|remaining), 0);
        chk("arst_paused", 32'(paused), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        ticks(3);
        chk("post_busy", 32'(busy), 0);
        chk("post_rem", 32'(|remaining), 0);
        chk("post_done", 32'(done_pulse), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
